// File: rtl/ysyx_22050854_axi_read_arbiter.sv
// ysyx_22050854_axi_read_arbiter: round-robin IFU/LSU arbiter sharing one AXI4 read port
module ysyx_22050854_axi_read_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter logic [3:0] IFU_ID = 4'b0001,
  parameter logic [3:0] LSU_ID = 4'b0010
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ifu_arvalid,
  output logic              ifu_arready,
  input  logic [ADDR_W-1:0] ifu_araddr,
  input  logic [7:0]        ifu_arlen,
  output logic              ifu_rvalid,
  input  logic              ifu_rready,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic [1:0]        ifu_rresp,
  output logic              ifu_rlast,
  input  logic              lsu_arvalid,
  output logic              lsu_arready,
  input  logic [ADDR_W-1:0] lsu_araddr,
  input  logic [7:0]        lsu_arlen,
  output logic              lsu_rvalid,
  input  logic              lsu_rready,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic [1:0]        lsu_rresp,
  output logic              lsu_rlast,
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [3:0]        m_arid,
  output logic [7:0]        m_arlen,
  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  input  logic [3:0]        m_rid,
  output logic              err
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  logic [1:0]        r_state;
  logic              r_gnt;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_len;
  logic [7:0]        r_cnt;
  logic [3:0]        r_id;
  logic              w_pick_lsu;
  logic              w_ifu;
  logic              w_lsu;
  logic              w_beat;
  logic              w_id_err;
  logic              w_len_err;
  logic [1:0]        w_resp;
  // r_gnt doubles as last_grant: it names the current owner and, once idle, the previous one
  always_comb begin
    w_pick_lsu = lsu_arvalid & (~ifu_arvalid | ~r_gnt);
    w_ifu      = (r_state == DATA) & ~r_gnt;
    w_lsu      = (r_state == DATA) & r_gnt;
    m_rready   = (w_ifu & ifu_rready) | (w_lsu & lsu_rready);
    w_beat     = m_rvalid & m_rready;
    w_id_err   = m_rid != r_id;
    w_len_err  = m_rlast ? (r_cnt != r_len) : (r_cnt == r_len);
    w_resp     = w_id_err ? 2'b10 : m_rresp;
  end
  assign m_arvalid   = r_state == ADDR;
  assign m_araddr    = r_addr;
  assign m_arid      = r_id;
  assign m_arlen     = r_len;
  assign ifu_arready = m_arvalid & ~r_gnt & m_arready;
  assign lsu_arready = m_arvalid & r_gnt & m_arready;
  assign ifu_rvalid  = w_ifu & m_rvalid;
  assign lsu_rvalid  = w_lsu & m_rvalid;
  assign ifu_rdata   = w_ifu ? m_rdata : '0;
  assign lsu_rdata   = w_lsu ? m_rdata : '0;
  assign ifu_rresp   = w_ifu ? w_resp : 2'b00;
  assign lsu_rresp   = w_lsu ? w_resp : 2'b00;
  assign ifu_rlast   = w_ifu & m_rlast;
  assign lsu_rlast   = w_lsu & m_rlast;
  assign err         = w_beat & (w_id_err | w_len_err);
  // grant in IDLE, issue AR in ADDR, count beats in DATA until the rlast handshake
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_gnt   <= 1'b1;
      r_addr  <= '0;
      r_len   <= '0;
      r_id    <= '0;
      r_cnt   <= '0;
    end else if (r_state == IDLE) begin
      if (ifu_arvalid | lsu_arvalid) begin
        r_state <= ADDR;
        r_gnt   <= w_pick_lsu;
        r_addr  <= w_pick_lsu ? lsu_araddr : ifu_araddr;
        r_len   <= w_pick_lsu ? lsu_arlen : ifu_arlen;
        r_id    <= w_pick_lsu ? LSU_ID : IFU_ID;
      end
    end else if (r_state == ADDR) begin
      if (m_arready) begin
        r_state <= DATA;
        r_cnt   <= '0;
      end
    end else if (r_state == DATA) begin
      if (w_beat) begin
        r_cnt <= r_cnt + 8'd1;
        if (m_rlast) r_state <= IDLE;
      end
    end else begin
      r_state <= IDLE;
    end
  end
endmodule

// File: tb/tb_ysyx_22050854_axi_read_arbiter.sv
// tb_ysyx_22050854_axi_read_arbiter: directed and randomized checks of the read arbiter
module tb_ysyx_22050854_axi_read_arbiter;
  logic        clock = 1'b0;
  logic        reset;
  logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready, ifu_rlast;
  logic [31:0] ifu_araddr;
  logic [7:0]  ifu_arlen;
  logic [63:0] ifu_rdata;
  logic [1:0]  ifu_rresp;
  logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready, lsu_rlast;
  logic [31:0] lsu_araddr;
  logic [7:0]  lsu_arlen;
  logic [63:0] lsu_rdata;
  logic [1:0]  lsu_rresp;
  logic        m_arvalid, m_arready, m_rvalid, m_rready, m_rlast, err;
  logic [31:0] m_araddr;
  logic [3:0]  m_arid, m_rid;
  logic [7:0]  m_arlen;
  logic [63:0] m_rdata;
  logic [1:0]  m_rresp;
  int checks = 0;
  int failures = 0;
  bit ml = 1'b1;

  ysyx_22050854_axi_read_arbiter dut (
    .clock(clock), .reset(reset),
    .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_araddr(ifu_araddr), .ifu_arlen(ifu_arlen),
    .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready), .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rlast(ifu_rlast),
    .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready), .lsu_araddr(lsu_araddr), .lsu_arlen(lsu_arlen),
    .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rlast(lsu_rlast),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arid(m_arid), .m_arlen(m_arlen),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rid(m_rid),
    .err(err)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_m_arvalid"}, m_arvalid, 0);
    chk({p, "_m_arid"}, m_arid, 0);
    chk({p, "_m_araddr"}, m_araddr, 0);
    chk({p, "_m_arlen"}, m_arlen, 0);
    chk({p, "_m_rready"}, m_rready, 0);
    chk({p, "_ifu_arready"}, ifu_arready, 0);
    chk({p, "_lsu_arready"}, lsu_arready, 0);
    chk({p, "_ifu_rvalid"}, ifu_rvalid, 0);
    chk({p, "_lsu_rvalid"}, lsu_rvalid, 0);
    chk({p, "_ifu_rlast"}, ifu_rlast, 0);
    chk({p, "_lsu_rlast"}, lsu_rlast, 0);
    chk({p, "_ifu_rdata"}, ifu_rdata, 0);
    chk({p, "_lsu_rdata"}, lsu_rdata, 0);
    chk({p, "_ifu_rresp"}, ifu_rresp, 0);
    chk({p, "_lsu_rresp"}, lsu_rresp, 0);
    chk({p, "_err"}, err, 0);
  endtask

  task automatic request(input bit vi, input logic [31:0] ai, input logic [7:0] li,
                         input bit vl, input logic [31:0] al, input logic [7:0] ll);
    if (vi) begin
      ifu_arvalid = 1'b1;
      ifu_araddr  = ai;
      ifu_arlen   = li;
    end
    if (vl) begin
      lsu_arvalid = 1'b1;
      lsu_araddr  = al;
      lsu_arlen   = ll;
    end
  endtask

  task automatic chk_beat(input bit g, input logic [63:0] d, input bit last, input logic [1:0] resp, input bit e);
    chk("rvalid_granted", g ? lsu_rvalid : ifu_rvalid, 1);
    chk("rvalid_other", g ? ifu_rvalid : lsu_rvalid, 0);
    chk("rdata", g ? lsu_rdata : ifu_rdata, d);
    chk("rlast", g ? lsu_rlast : ifu_rlast, last);
    chk("rresp", g ? lsu_rresp : ifu_rresp, resp);
    chk("err", err, e);
  endtask

  // One whole transaction as seen by the memory: winner predicted from pending requests and last grant.
  task automatic serve(input int ar_dly, input int len_delta, input int bad_beat, input int abort_at);
    bit g, last, hold;
    logic [3:0] id, rid;
    logic [31:0] a;
    logic [7:0] l;
    logic [63:0] d;
    logic [1:0] rr, resp;
    int w, nb, gaps;
    g  = (ifu_arvalid && lsu_arvalid) ? !ml : lsu_arvalid;
    id = g ? 4'd2 : 4'd1;
    a  = g ? lsu_araddr : ifu_araddr;
    l  = g ? lsu_arlen : ifu_arlen;
    w  = 0;
    forever begin
      m_arready = 1'b0;
      m_rlast   = 1'b0;
      m_rid     = 4'd0;
      m_rvalid  = 1'($urandom_range(0, 1));
      #1;
      chk("nodata_rready", m_rready, 0);
      chk("nodata_rvalid", ifu_rvalid | lsu_rvalid, 0);
      chk("nodata_err", err, 0);
      if (m_arvalid || w == 8) break;
      @(negedge clock);
      w++;
    end
    m_rvalid = 1'b0;
    chk("ar_latency", w, 1);
    chk("m_arid", m_arid, id);
    chk("m_araddr", m_araddr, a);
    chk("m_arlen", m_arlen, l);
    ml = g;
    for (int i = 0; i < ar_dly; i++) begin
      chk("arready_early", ifu_arready | lsu_arready, 0);
      @(negedge clock);
      #1;
      chk("arvalid_held", m_arvalid, 1);
      chk("araddr_held", m_araddr, a);
    end
    m_arready = 1'b1;
    #1;
    chk("arready_granted", g ? lsu_arready : ifu_arready, 1);
    chk("arready_other", g ? ifu_arready : lsu_arready, 0);
    @(negedge clock);
    m_arready = 1'b0;
    if (g) lsu_arvalid = 1'b0;
    else ifu_arvalid = 1'b0;
    nb = l + 1 + len_delta;
    if (nb < 1) nb = 1;
    for (int b = 0; b < nb; b++) begin
      if (b == abort_at) return;
      gaps = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2) : 0;
      repeat (gaps) begin
        m_rvalid   = 1'b0;
        ifu_rready = 1'($urandom_range(0, 1));
        lsu_rready = 1'($urandom_range(0, 1));
        #1;
        chk("gap_rvalid", ifu_rvalid | lsu_rvalid, 0);
        chk("gap_err", err, 0);
        chk("gap_rready", m_rready, g ? lsu_rready : ifu_rready);
        @(negedge clock);
      end
      last     = (b == nb - 1);
      d        = {$urandom, $urandom};
      rr       = 2'($urandom_range(0, 1));
      rid      = (b == bad_beat) ? 4'd3 : id;
      resp     = (rid != id) ? 2'b10 : rr;
      m_rvalid = 1'b1;
      m_rdata  = d;
      m_rresp  = rr;
      m_rlast  = last;
      m_rid    = rid;
      hold     = ($urandom_range(0, 2) == 0);
      if (hold) begin
        if (g) begin lsu_rready = 1'b0; ifu_rready = 1'($urandom_range(0, 1)); end
        else begin ifu_rready = 1'b0; lsu_rready = 1'($urandom_range(0, 1)); end
        #1;
        chk_beat(g, d, last, resp, 1'b0);
        chk("hold_rready", m_rready, 0);
        @(negedge clock);
      end
      if (g) begin lsu_rready = 1'b1; ifu_rready = 1'($urandom_range(0, 1)); end
      else begin ifu_rready = 1'b1; lsu_rready = 1'($urandom_range(0, 1)); end
      #1;
      chk_beat(g, d, last, resp, (rid != id) || (last ? (b != int'(l)) : (b == int'(l))));
      chk("beat_rready", m_rready, 1);
      @(negedge clock);
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
  endtask

  initial begin
    int v, dl;
    reset = 1'b1;
    {ifu_arvalid, ifu_rready, lsu_arvalid, lsu_rready} = '0;
    {ifu_araddr, ifu_arlen, lsu_araddr, lsu_arlen} = '0;
    {m_arready, m_rvalid, m_rlast, m_rid, m_rresp} = '0;
    m_rdata = 64'hdead_beef_cafe_f00d;
    repeat (3) @(negedge clock);
    {m_arready, m_rvalid, m_rlast, ifu_rready, lsu_rready} = '1;
    #1;
    chk_reset("por");
    @(negedge clock);
    reset = 1'b0;
    {m_arready, m_rvalid, m_rlast} = '0;
    request(1, 32'h8000_1000, 8'd1, 1, 32'h8000_2000, 8'd2);
    serve(0, 0, -1, -1);
    serve(1, 0, -1, -1);
    request(1, 32'h8000_0000, 8'd0, 0, 32'h0, 8'd0);
    serve(0, 0, -1, -1);
    request(1, 32'h8000_1100, 8'd0, 1, 32'h8000_2100, 8'd1);
    serve(0, 0, -1, -1);
    serve(0, 0, -1, -1);
    request(0, 32'h0, 8'd0, 1, 32'h8000_3000, 8'd3);
    serve(2, 0, -1, -1);
    request(1, 32'h8000_4000, 8'd2, 0, 32'h0, 8'd0);
    serve(0, 0, 1, -1);
    request(1, 32'h8000_5000, 8'd1, 1, 32'h8000_6000, 8'd3);
    serve(0, -2, -1, -1);
    serve(1, 0, -1, -1);
    request(1, 32'h8000_7000, 8'd1, 0, 32'h0, 8'd0);
    serve(0, 1, -1, -1);
    repeat (25) begin
      v = $urandom_range(1, 3);
      request(v[0], $urandom, 8'($urandom_range(0, 7)), v[1], $urandom, 8'($urandom_range(0, 7)));
      while (ifu_arvalid || lsu_arvalid) begin
        dl = ($urandom_range(0, 5) == 0) ? 1 : (($urandom_range(0, 5) == 0) ? -1 : 0);
        serve($urandom_range(0, 3), dl, ($urandom_range(0, 4) == 0) ? $urandom_range(0, 2) : -1, -1);
      end
    end
    request(0, 32'h0, 8'd0, 1, 32'h8000_8000, 8'd7);
    serve(0, 0, -1, 2);
    reset = 1'b1;
    {m_arready, m_rvalid, m_rlast, ifu_rready, lsu_rready} = '1;
    @(negedge clock);
    #1;
    chk_reset("midburst");
    reset = 1'b0;
    {m_arready, m_rvalid, m_rlast} = '0;
    ml = 1'b1;
    request(1, 32'h8000_9000, 8'd1, 1, 32'h8000_a000, 8'd0);
    serve(0, 0, -1, -1);
    serve(0, 0, -1, -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
